// File: rtl/ram_burst_reader.sv
// Burst read initiator for a 16x8 synchronous-read RAM: issues consecutive addresses,
// absorbs the two-cycle read latency and streams words through a 4-deep output FIFO.
// Define BURST_READER_CHKSUM_EN to add the running XOR checksum output `chksum`.
module ram_burst_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   burst_len,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last
`ifdef BURST_READER_CHKSUM_EN
  ,
  output logic [DATA_WIDTH-1:0] chksum
`endif
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH:0]   r_len;
  logic [ADDR_WIDTH:0]   r_issued;
  logic [ADDR_WIDTH-1:0] r_next_addr;

  logic                  r_vld_p0, r_last_p0;
  logic                  r_vld_p1, r_last_p1;

  logic [DATA_WIDTH-1:0] r_mem [4];
  logic                  r_last_mem [4];
  logic [1:0]            r_wr_ptr, r_rd_ptr;
  logic [2:0]            r_count;

  logic                  w_accept;
  logic [2:0]            w_inflight;
  logic                  w_room;
  logic                  w_issue;
  logic                  w_final_issue;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_last_hs;

  assign w_accept      = (r_state == S_IDLE) && start;
  assign w_inflight    = {2'b00, r_vld_p0} + {2'b00, r_vld_p1};
  // Counting in-flight reads as occupied slots means the FIFO can never overflow.
  assign w_room        = (r_count + w_inflight) < 3'd4;
  assign w_issue       = (r_state == S_READ) && (r_issued != r_len) && w_room;
  assign w_final_issue = w_issue && ((r_issued + 1'b1) == r_len);
  assign w_push        = r_vld_p1;
  assign w_pop         = out_valid && out_ready;
  assign w_last_hs     = w_pop && r_last_mem[r_rd_ptr];

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign out_valid = (r_count != 3'd0);
  assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
  assign out_last  = out_valid && r_last_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_len    <= '0;
      r_issued <= '0;
      ram_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_len    <= burst_len;
            r_issued <= '0;
            r_state  <= S_READ;
          end
        end
        S_READ: begin
          if (r_len == '0)
            r_state <= S_DONE;
          else if (w_final_issue)
            r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (w_last_hs)
            r_state <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_issue) begin
        ram_addr <= r_next_addr;
        r_issued <= r_issued + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept)
      r_next_addr <= base_addr;
    else if (w_issue)
      r_next_addr <= r_next_addr + 1'b1;
  end

  // p0: address registered toward the RAM
  // p1: RAM has registered the address; ram_rdata valid next edge
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_p0  <= 1'b0;
      r_last_p0 <= 1'b0;
      r_vld_p1  <= 1'b0;
      r_last_p1 <= 1'b0;
    end else begin
      r_vld_p0  <= w_issue;
      r_last_p0 <= w_final_issue;
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
    end
  end

  // p2: capture RAM word into the output FIFO
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr]      <= ram_rdata;
      r_last_mem[r_wr_ptr] <= r_last_p1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef BURST_READER_CHKSUM_EN
  always_ff @(posedge clk) begin
    if (reset || w_accept)
      chksum <= '0;
    else if (w_pop)
      chksum <= chksum ^ out_data;
  end
`endif

endmodule
